// File: rtl/ai_dense_pkg.sv
// Shared types and width helpers for the dense-layer engine.
package ai_dense_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  localparam int SHIFT_W = 5;

  // Width of a length field able to hold 0..dim.
  function automatic int len_w(input int dim);
    return $clog2(dim + 1);
  endfunction

  // Width of an index field able to address 0..dim-1.
  function automatic int idx_w(input int dim);
    return $clog2(dim);
  endfunction

  localparam int DEF_IN_DIM     = 32;
  localparam int DEF_OUT_DIM    = 32;
  localparam int DEF_IN_LEN_W   = len_w(DEF_IN_DIM);
  localparam int DEF_OUT_LEN_W  = len_w(DEF_OUT_DIM);
  localparam int DEF_OUT_IDX_W  = idx_w(DEF_OUT_DIM);
  localparam int DEF_IN_IDX_W   = idx_w(DEF_IN_DIM);

endpackage

// File: rtl/ai_dense_engine_if.sv
// Activation input stream and result output stream of the dense engine.
// The engine connects through the slave modport, the driver of the streams
// through the master modport.
interface ai_dense_engine_if
  import ai_dense_pkg::*;
#(
  parameter int AW   = 8,
  parameter int OW   = 8,
  parameter int IDXW = DEF_OUT_IDX_W
);
  logic                   act_valid;
  logic                   act_ready;
  logic signed [AW-1:0]   act_in;
  logic                   res_valid;
  logic                   res_ready;
  logic signed [OW-1:0]   res_data;
  logic [IDXW-1:0]        res_idx;

  modport master (
    output act_valid, act_in, res_ready,
    input  act_ready, res_valid, res_data, res_idx
  );

  modport slave (
    input  act_valid, act_in, res_ready,
    output act_ready, res_valid, res_data, res_idx
  );
endinterface

// File: rtl/ai_dense_requant.sv
// Combinational requantisation: arithmetic right shift, optional ReLU, then
// reduction to the output width. Defining AI_DENSE_SAT_EN makes the
// reduction saturate; otherwise the low OW bits are kept.
module ai_dense_requant
  import ai_dense_pkg::*;
#(
  parameter int ACCW = 20,
  parameter int OW   = 8
)(
  input  logic signed [ACCW-1:0]  i_acc,
  input  logic [SHIFT_W-1:0]      i_shift,
  input  logic                    i_relu,
  output logic signed [OW-1:0]    o_data
);

  function automatic logic signed [ACCW-1:0] relu_fn(
    input logic signed [ACCW-1:0] v,
    input logic                   en
  );
    return (en && (v < 0)) ? '0 : v;
  endfunction

  logic signed [ACCW-1:0] w_shifted;
  logic signed [ACCW-1:0] w_relu;

  assign w_shifted = i_acc >>> i_shift;
  assign w_relu    = relu_fn(w_shifted, i_relu);

`ifdef AI_DENSE_SAT_EN
  localparam logic signed [ACCW-1:0] SAT_HI = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_LO = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  function automatic logic signed [OW-1:0] sat_ow(input logic signed [ACCW-1:0] v);
    if (v > SAT_HI) return SAT_HI[OW-1:0];
    if (v < SAT_LO) return SAT_LO[OW-1:0];
    return v[OW-1:0];
  endfunction

  assign o_data = sat_ow(w_relu);
`else
  function automatic logic signed [OW-1:0] trunc_ow(input logic signed [ACCW-1:0] v);
    return OW'(v);
  endfunction

  assign o_data = trunc_ow(w_relu);
`endif

endmodule

// File: rtl/ai_dense_engine.sv
// Dense (fully connected) layer engine. Activations stream in one per
// handshake; each one is multiplied against a whole weight column and added
// to every active neuron accumulator in the same cycle. After in_len inputs
// the biased sums are requantised and streamed out one neuron at a time.
// Optional build macro: AI_DENSE_SAT_EN (saturating output width reduction).
module ai_dense_engine
  import ai_dense_pkg::*;
#(
  parameter int IN_DIM  = 32,
  parameter int OUT_DIM = 32,
  parameter int AW      = 8,
  parameter int WW      = 4,
  parameter int ACCW    = 20,
  parameter int OW      = 8,
  localparam int INL_W  = len_w(IN_DIM),
  localparam int OUTL_W = len_w(OUT_DIM),
  localparam int KIDX_W = idx_w(IN_DIM),
  localparam int NIDX_W = idx_w(OUT_DIM),
  localparam int WA_W   = $clog2(OUT_DIM*IN_DIM)
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [INL_W-1:0]        in_len,
  input  logic [OUTL_W-1:0]       out_len,
  input  logic                    relu_en,
  input  logic [SHIFT_W-1:0]      shift,
  input  logic                    w_we,
  input  logic [WA_W-1:0]         w_addr,
  input  logic signed [WW-1:0]    w_data,
  input  logic                    b_we,
  input  logic [NIDX_W-1:0]       b_addr,
  input  logic signed [ACCW-1:0]  b_data,
  output logic                    busy,
  output logic                    done,
  ai_dense_engine_if.slave        bus
);

  state_t                 r_state;
  state_t                 w_next;
  logic [INL_W-1:0]       r_in_len;
  logic [OUTL_W-1:0]      r_out_len;
  logic                   r_relu;
  logic [SHIFT_W-1:0]     r_shift;
  logic [KIDX_W-1:0]      r_k;
  logic [NIDX_W-1:0]      r_idx;
  logic                   r_done;

  logic signed [ACCW-1:0] r_acc  [OUT_DIM];
  logic signed [WW-1:0]   r_wmem [OUT_DIM][IN_DIM];
  logic signed [ACCW-1:0] r_bmem [OUT_DIM];

  logic                   w_act_ready;
  logic                   w_res_valid;
  logic                   w_start_ok;
  logic                   w_act_hs;
  logic                   w_res_hs;
  logic                   w_last_act;
  logic                   w_last_res;
  logic [INL_W-1:0]       w_in_len_eff;
  logic [OUTL_W-1:0]      w_out_len_eff;
  logic [NIDX_W-1:0]      w_wn;
  logic [KIDX_W-1:0]      w_wk;
  logic                   w_waddr_ok;
  logic signed [AW+WW-1:0] w_act_x;
  logic signed [AW+WW-1:0] w_prod     [OUT_DIM];
  logic signed [ACCW-1:0]  w_prod_ext [OUT_DIM];
  logic signed [ACCW-1:0]  w_sum;
  logic signed [OW-1:0]    w_req;

  assign w_start_ok = start && (r_state == ST_IDLE);
  assign w_act_hs   = bus.act_valid && w_act_ready;
  assign w_res_hs   = w_res_valid && bus.res_ready;
  assign w_last_act = (INL_W'(r_k) == (r_in_len - INL_W'(1)));
  assign w_last_res = (OUTL_W'(r_idx) == (r_out_len - OUTL_W'(1)));

  // A zero or oversized length means "use the full dimension".
  assign w_in_len_eff  = ((in_len == '0) || (int'(in_len) > IN_DIM))
                         ? INL_W'(IN_DIM) : in_len;
  assign w_out_len_eff = ((out_len == '0) || (int'(out_len) > OUT_DIM))
                         ? OUTL_W'(OUT_DIM) : out_len;

  // Flat weight address split into neuron row and input column.
  assign w_wn       = NIDX_W'(int'(w_addr) / IN_DIM);
  assign w_wk       = KIDX_W'(int'(w_addr) % IN_DIM);
  assign w_waddr_ok = int'(w_addr) < (OUT_DIM * IN_DIM);

  // One multiplier per neuron, all fed by the current weight column.
  assign w_act_x = {{WW{bus.act_in[AW-1]}}, bus.act_in};
  for (genvar n = 0; n < OUT_DIM; n++) begin : g_mac
    logic signed [AW+WW-1:0] w_wt_x;
    assign w_wt_x        = {{AW{r_wmem[n][r_k][WW-1]}}, r_wmem[n][r_k]};
    assign w_prod[n]     = w_act_x * w_wt_x;
    assign w_prod_ext[n] = {{(ACCW-AW-WW){w_prod[n][AW+WW-1]}}, w_prod[n]};
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next      = r_state;
    w_act_ready = 1'b0;
    w_res_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_MAC;
      end
      ST_MAC: begin
        w_act_ready = 1'b1;
        if (bus.act_valid && w_last_act) w_next = ST_EMIT;
      end
      ST_EMIT: begin
        w_res_valid = 1'b1;
        if (bus.res_ready && w_last_res) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Latched run configuration, input/output counters and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_len  <= '0;
      r_out_len <= '0;
      r_relu    <= 1'b0;
      r_shift   <= '0;
      r_k       <= '0;
      r_idx     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_res_hs && w_last_res;
      if (w_start_ok) begin
        r_in_len  <= w_in_len_eff;
        r_out_len <= w_out_len_eff;
        r_relu    <= relu_en;
        r_shift   <= shift;
        r_k       <= '0;
        r_idx     <= '0;
      end
      if (w_act_hs) r_k <= r_k + 1'b1;
      if (w_res_hs) r_idx <= w_last_res ? '0 : r_idx + 1'b1;
    end
  end

  // Accumulators: cleared at start, updated for active neurons on each input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < OUT_DIM; n++) r_acc[n] <= '0;
    end else if (w_start_ok) begin
      for (int n = 0; n < OUT_DIM; n++) r_acc[n] <= '0;
    end else if (w_act_hs) begin
      for (int n = 0; n < OUT_DIM; n++) begin
        if (n < int'(r_out_len)) r_acc[n] <= r_acc[n] + w_prod_ext[n];
      end
    end
  end

  // Weight store: writable only while idle, keeps contents across reset.
  always_ff @(posedge clk) begin
    if (w_we && (r_state == ST_IDLE) && w_waddr_ok) r_wmem[w_wn][w_wk] <= w_data;
  end

  // Bias store: writable only while idle, keeps contents across reset.
  always_ff @(posedge clk) begin
    if (b_we && (r_state == ST_IDLE)) r_bmem[b_addr] <= b_data;
  end

  assign w_sum = r_acc[r_idx] + r_bmem[r_idx];

  ai_dense_requant #(
    .ACCW (ACCW),
    .OW   (OW)
  ) u_requant (
    .i_acc   (w_sum),
    .i_shift (r_shift),
    .i_relu  (r_relu),
    .o_data  (w_req)
  );

  assign bus.act_ready = w_act_ready;
  assign bus.res_valid = w_res_valid;
  assign bus.res_data  = w_res_valid ? w_req : '0;
  assign bus.res_idx   = r_idx;
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;

endmodule

// File: tb/tb_ai_dense_engine.sv
// Bench for ai_dense_engine: directed vectors plus randomized layers checked
// against a behavioural dense-layer model.
module tb_ai_dense_engine;
  import ai_dense_pkg::*;

  localparam int IN_DIM  = 32;
  localparam int OUT_DIM = 32;
  localparam int AW      = 8;
  localparam int WW      = 4;
  localparam int ACCW    = 20;
  localparam int OW      = 8;
  localparam int INL_W   = len_w(IN_DIM);
  localparam int OUTL_W  = len_w(OUT_DIM);
  localparam int NIDX_W  = idx_w(OUT_DIM);
  localparam int WA_W    = $clog2(OUT_DIM*IN_DIM);

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [INL_W-1:0]       in_len;
  logic [OUTL_W-1:0]      out_len;
  logic                   relu_en;
  logic [SHIFT_W-1:0]     shift;
  logic                   w_we;
  logic [WA_W-1:0]        w_addr;
  logic signed [WW-1:0]   w_data;
  logic                   b_we;
  logic [NIDX_W-1:0]      b_addr;
  logic signed [ACCW-1:0] b_data;
  logic                   busy;
  logic                   done;

  ai_dense_engine_if #(.AW(AW), .OW(OW), .IDXW(NIDX_W)) bus();

  ai_dense_engine #(
    .IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .AW(AW), .WW(WW), .ACCW(ACCW), .OW(OW)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_len(in_len), .out_len(out_len),
    .relu_en(relu_en), .shift(shift), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .b_we(b_we), .b_addr(b_addr), .b_data(b_data), .busy(busy), .done(done),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int mw [OUT_DIM][IN_DIM];
  int mb [OUT_DIM];
  int acts [IN_DIM];
  int got [OUT_DIM];
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input int got_v, input int exp_v);
    n_cmp++;
    if (got_v != exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
    end
  endtask

  // Reference: dot product, bias, wrap to ACCW, floor-divide by 2^shift,
  // optional ReLU, then reduce to OW bits.
  function automatic int model_res(input int n, input int il, input int sh, input bit relu);
    longint s, d, r;
    s = 0;
    for (int k = 0; k < il; k++) s += longint'(acts[k]) * longint'(mw[n][k]);
    s += mb[n];
    s = s & ((longint'(1) << ACCW) - 1);
    if (s >= (longint'(1) << (ACCW-1))) s -= (longint'(1) << ACCW);
    d = longint'(1) << sh;
    if (s >= 0) s = s / d;
    else        s = -((-s + d - 1) / d);
    if (relu && s < 0) s = 0;
`ifdef AI_DENSE_SAT_EN
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    r = s;
`else
    r = s & 255;
    if (r > 127) r -= 256;
`endif
    return int'(r);
  endfunction

  // All drive tasks start and end on a falling edge.
  task automatic wr_w(input int n, input int k, input int v);
    w_we = 1'b1; w_addr = WA_W'(n*IN_DIM + k); w_data = WW'(v);
    @(negedge clk);
    w_we = 1'b0;
    mw[n][k] = v;
  endtask

  task automatic wr_b(input int n, input int v);
    b_we = 1'b1; b_addr = NIDX_W'(n); b_data = ACCW'(v);
    @(negedge clk);
    b_we = 1'b0;
    mb[n] = v;
  endtask

  task automatic poke_busy();
    w_we   = 1'b1;
    w_addr = WA_W'($urandom_range(OUT_DIM*IN_DIM-1));
    w_data = WW'($urandom_range(15));
    b_we   = 1'($urandom_range(1));
    b_addr = NIDX_W'($urandom_range(OUT_DIM-1));
    b_data = ACCW'($urandom);
    start  = 1'($urandom_range(1));
    in_len = INL_W'($urandom_range(1, 3));
  endtask

  task automatic run_layer(input int il_raw, input int ol_raw, input bit relu, input int sh,
                           input int gap_pct, input int stall_idx, input int stall_len,
                           input bit rnd_stall, input bit poke);
    int il, ol, g, nst, exp_v;
    il = (il_raw == 0 || il_raw > IN_DIM)  ? IN_DIM  : il_raw;
    ol = (ol_raw == 0 || ol_raw > OUT_DIM) ? OUT_DIM : ol_raw;
    start = 1'b1; in_len = INL_W'(il_raw); out_len = OUTL_W'(ol_raw);
    relu_en = relu; shift = SHIFT_W'(sh);
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", int'(busy), 1);
    check_eq("done_low_after_start", int'(done), 0);
    for (int k = 0; k < il; k++) begin
      g = 0;
      while (g < 4 && $urandom_range(99) < gap_pct) begin
        bus.act_valid = 1'b0;
        if (poke) poke_busy();
        @(negedge clk);
        g++;
      end
      bus.act_valid = 1'b1;
      bus.act_in    = AW'(acts[k]);
      if (poke) poke_busy();
      check_eq("act_ready", int'(bus.act_ready), 1);
      @(negedge clk);
    end
    bus.act_valid = 1'b0; w_we = 1'b0; b_we = 1'b0; start = 1'b0;
    check_eq("first_res_valid", int'(bus.res_valid), 1);
    for (int i = 0; i < ol; i++) begin
      exp_v  = model_res(i, il, sh, relu);
      got[i] = int'($signed(bus.res_data));
      check_eq("res_valid", int'(bus.res_valid), 1);
      check_eq("res_idx", int'(bus.res_idx), i);
      check_eq("res_data", got[i], exp_v);
      check_eq("done_early", int'(done), 0);
      nst = (i == stall_idx) ? stall_len : (rnd_stall ? $urandom_range(2) : 0);
      for (int s = 0; s < nst; s++) begin
        bus.res_ready = 1'b0;
        @(negedge clk);
        check_eq("hold_idx", int'(bus.res_idx), i);
        check_eq("hold_data", int'($signed(bus.res_data)), got[i]);
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
    end
    bus.res_ready = 1'b0;
    check_eq("done_pulse", int'(done), 1);
    check_eq("busy_end", int'(busy), 0);
    check_eq("res_valid_end", int'(bus.res_valid), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_act_ready"}, int'(bus.act_ready), 0);
    check_eq({tag, "_res_valid"}, int'(bus.res_valid), 0);
    check_eq({tag, "_res_data"},  int'(bus.res_data), 0);
    check_eq({tag, "_res_idx"},   int'(bus.res_idx), 0);
    check_eq({tag, "_busy"},      int'(busy), 0);
    check_eq({tag, "_done"},      int'(done), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int il, ol;
    reset = 1'b1; start = 1'b0; in_len = '0; out_len = '0; relu_en = 1'b0; shift = '0;
    w_we = 1'b0; w_addr = '0; w_data = '0; b_we = 1'b0; b_addr = '0; b_data = '0;
    bus.act_valid = 1'b0; bus.act_in = '0; bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);

    for (int n = 0; n < OUT_DIM; n++) begin
      for (int k = 0; k < IN_DIM; k++) wr_w(n, k, 0);
      wr_b(n, 0);
    end
    for (int k = 0; k < IN_DIM; k++) acts[k] = 0;

    // Identity weights
    for (int n = 0; n < 4; n++) wr_w(n, n, 1);
    acts[0] = 3; acts[1] = -2; acts[2] = 5; acts[3] = 7;
    run_layer(4, 4, 1'b0, 0, 0, -1, 0, 1'b0, 1'b0);
    check_eq("id_0", got[0], 3);
    check_eq("id_1", got[1], -2);
    check_eq("id_2", got[2], 5);
    check_eq("id_3", got[3], 7);

    // Same with ReLU, started in the done cycle of the previous run
    run_layer(4, 4, 1'b1, 0, 0, -1, 0, 1'b0, 1'b0);
    check_eq("relu_0", got[0], 3);
    check_eq("relu_1", got[1], 0);
    check_eq("relu_2", got[2], 5);
    check_eq("relu_3", got[3], 7);

    // Negative bias with shift: -10 >>> 2 = -3
    wr_b(0, -10);
    for (int k = 0; k < IN_DIM; k++) acts[k] = 0;
    run_layer(4, 4, 1'b0, 2, 0, -1, 0, 1'b0, 1'b0);
    check_eq("bias_shift_0", got[0], -3);

    // Overflow of the output width: 4*127*7 = 3556
    wr_b(0, 0);
    for (int n = 0; n < 4; n++) for (int k = 0; k < 4; k++) wr_w(n, k, 7);
    for (int k = 0; k < 4; k++) acts[k] = 127;
    run_layer(4, 4, 1'b0, 0, 0, -1, 0, 1'b0, 1'b0);
`ifdef AI_DENSE_SAT_EN
    check_eq("wide_0", got[0], 127);
`else
    check_eq("wide_0", got[0], -28);
`endif

    // Output back-pressure: hold res_ready low 5 cycles at index 1
    for (int k = 0; k < 4; k++) acts[k] = $urandom_range(255) - 128;
    run_layer(4, 4, 1'b0, 0, 0, 1, 5, 1'b0, 1'b0);

    // Reset after two accepted activations aborts the run without done
    start = 1'b1; in_len = INL_W'(4); out_len = OUTL_W'(4); relu_en = 1'b0; shift = '0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.act_valid = 1'b1; bus.act_in = AW'(acts[k]);
      @(negedge clk);
    end
    bus.act_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("midrst_no_done", int'(done), 0);
      check_eq("midrst_idle", int'(busy), 0);
    end
    run_layer(4, 4, 1'b0, 0, 0, -1, 0, 1'b0, 1'b0);

    // Randomized layers with gaps, stalls and writes/starts while busy
    for (int t = 0; t < 4; t++) begin
      for (int n = 0; n < OUT_DIM; n++) begin
        for (int k = 0; k < IN_DIM; k++) wr_w(n, k, $urandom_range(15) - 8);
        wr_b(n, $urandom_range((1 << ACCW) - 1) - (1 << (ACCW-1)));
      end
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < IN_DIM; k++) acts[k] = $urandom_range(255) - 128;
        il = (r == 0) ? 0 : $urandom_range(40);
        ol = (r == 1) ? 63 : $urandom_range(40);
        run_layer(il, ol, 1'($urandom_range(1)), $urandom_range(12), 30, -1, 0,
                  1'b1, 1'(t % 2));
      end
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ai_dense_engine.md
AI_DENSE_ENGINE -- requirements
Module: ai_dense_engine

Interface
REQ-001 SHALL have parameter IN_DIM, default 32, maximum inputs per neuron.
REQ-002 SHALL have parameter OUT_DIM, default 32, maximum neurons.
REQ-003 SHALL have parameter AW, default 8, signed activation width.
REQ-004 SHALL have parameter WW, default 4, signed weight width.
REQ-005 SHALL have parameter ACCW, default 20, accumulator and bias width; ACCW >= AW+WW+clog2(IN_DIM).
REQ-006 SHALL have parameter OW, default 8, signed result width.
REQ-007 SHALL have clk, input, 1 bit, clock. Reset is reset, asynchronous, active-high; clock is clk.
REQ-008 SHALL have reset, input, 1 bit, asynchronous active-high reset.
REQ-009 SHALL have start, input, 1 bit, begin a run using the config inputs.
REQ-010 SHALL have in_len and out_len, input, clog2(DIM+1) bits each, active inputs and neurons.
REQ-011 SHALL have relu_en, input, 1 bit, and shift, input, 5 bits, both latched at start.
REQ-012 SHALL have w_we, input, 1 bit; w_addr, input, clog2(OUT_DIM*IN_DIM) bits; w_data, input, WW bits. Weight index is neuron*IN_DIM+input.
REQ-013 SHALL have b_we, input, 1 bit; b_addr, input, clog2(OUT_DIM) bits; b_data, input, ACCW bits.
REQ-014 SHALL have act_valid, input, 1 bit; act_ready, output, 1 bit; act_in, input, AW bits.
REQ-015 SHALL have res_valid, output, 1 bit; res_ready, input, 1 bit; res_data, output, OW bits; res_idx, output, clog2(OUT_DIM) bits.
REQ-016 SHALL have busy, output, 1 bit, and done, output, 1 bit (one-cycle pulse).

Function
REQ-017 SHALL implement states IDLE, MAC, EMIT.
REQ-018 IDLE->MAC on start: clear all accumulators; latch relu_en, shift, in_len, out_len.
REQ-019 SHALL clamp in_len or out_len values of 0 or above DIM to IN_DIM or OUT_DIM.
REQ-020 start while busy SHALL be ignored.
REQ-021 act_ready SHALL equal (state==MAC). Each act_valid&&act_ready handshake k SHALL add act_in*W[n][k] to acc[n] for every n < out_len, in the same clock.
REQ-022 MAC->EMIT SHALL occur on the in_len-th handshake; the first res_valid SHALL follow 1 cycle later.
REQ-023 Products SHALL be sign-extended to ACCW; sums SHALL wrap modulo 2^ACCW.
REQ-024 In EMIT, res_idx SHALL start at 0; res_data = requant(acc[res_idx]+B[res_idx]).
REQ-025 requant SHALL be an arithmetic right shift by shift, then ReLU (negative->0) if relu_en, then width reduction to OW.
REQ-026 res_valid SHALL stay high and res_data/res_idx SHALL stay stable until res_ready; each handshake SHALL increment res_idx.
REQ-027 The handshake at res_idx==out_len-1 SHALL return to IDLE; done SHALL pulse in the next cycle.
REQ-028 busy SHALL equal (state!=IDLE).
REQ-029 Weight and bias writes SHALL apply only in IDLE and SHALL be ignored while busy.
REQ-030 A new start in the same cycle as done SHALL be accepted.

Reset
REQ-031 reset SHALL force IDLE and clear the accumulators and latched config.
REQ-032 At reset, act_ready, res_valid, res_data, res_idx, busy and done SHALL all be 0.
REQ-033 Reset mid-run SHALL abort the run with no done pulse.
REQ-034 Weight and bias storage SHALL NOT be reset.

Configuration
REQ-035 With macro AI_DENSE_SAT_EN defined, width reduction SHALL saturate to [-2^(OW-1), 2^(OW-1)-1].
REQ-036 Without AI_DENSE_SAT_EN, width reduction SHALL truncate to the low OW bits.

Structure
REQ-037 Package ai_dense_pkg SHALL hold the state_t enum and the localparams for the shift width and index widths.
REQ-038 Sub-module ai_dense_requant SHALL be the combinational shift/ReLU/width-reduction stage, instantiated once on the muxed output.

Verification
REQ-039 Reset: assert reset mid-MAC after 2 acts -> all outputs 0, state IDLE, no done; a rerun gives correct results.
REQ-040 Identity: IN/OUT len 4, W diagonal 1, B 0, shift 0, relu off, acts 3,-2,5,7 -> res_data 3,-2,5,7 on res_idx 0..3; done one cycle after the last handshake.
REQ-041 Same stimulus with relu_en=1 -> 3,0,5,7. Then B[0]=-10, acts 0, shift 2 -> res_data[0] = -3.
REQ-042 All W=7, in_len 4, acts 127, shift 0: sum 3556 -> 127 with AI_DENSE_SAT_EN; -28 (0xE4) without.
REQ-043 Hold res_ready low for 5 cycles at res_idx 1 -> res_data and res_idx held, no skipped index; done only after the res_idx 3 handshake.
REQ-044 Drive w_we during MAC with act_valid gaps and start while busy -> weights unchanged, run unaffected, results match the golden model.
